// File: rtl/dma_pkg.sv
// Shared types and defaults for the memory-copier DMA controller.
package dma_pkg;
  localparam int DATA_W     = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LEN_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    FINISH
  } state_t;
endpackage

// File: rtl/dma_copy_ctrl_if.sv
// Byte-memory request bus between the copy controller and memory.
interface dma_copy_ctrl_if
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) ();
  logic              mem_ren;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/dma_addr_counter.sv
// Latched transfer parameters and byte index with wrapped addresses.
module dma_addr_counter
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [LEN_W-1:0]  len_in,
  output logic [ADDR_W-1:0] src_a,
  output logic [ADDR_W-1:0] dst_a,
  output logic              last
);
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  idx;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      src <= '0;
      dst <= '0;
      len <= '0;
      idx <= '0;
    end else if (load) begin
      src <= src_in;
      dst <= dst_in;
      len <= len_in;
      idx <= '0;
    end else if (inc) begin
      idx <= idx + LEN_W'(1);
    end
  end

  assign src_a = src + ADDR_W'(idx);
  assign dst_a = dst + ADDR_W'(idx);
  assign last  = (idx == len - LEN_W'(1));
endmodule

// File: rtl/dma_copy_ctrl.sv
// Byte-at-a-time copy sequencer: read into staging reg, write back out.
module dma_copy_ctrl
  import dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  dma_copy_ctrl_if.master   mem,
  output logic              reg_wen,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_data,
  output logic              busy,
  output logic              done,
  output logic              aborted
);
  state_t            state;
  state_t            nxt;
  logic              take_abort;
  logic              ren;
  logic              wen;
  logic              last;
  logic [ADDR_W-1:0] src_a;
  logic [ADDR_W-1:0] dst_a;

  wire load = (state == IDLE) && start;
  wire inc  = (state == WR_REQ) && mem.mem_ready
              && !abort && !last;

  dma_addr_counter #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .load  (load),
    .inc   (inc),
    .src_in(src_addr),
    .dst_in(dst_addr),
    .len_in(length),
    .src_a (src_a),
    .dst_a (dst_a),
    .last  (last)
  );

  always_comb begin
    nxt        = state;
    take_abort = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          nxt = (length == '0) ? FINISH : RD_REQ;
      end
      RD_REQ: begin
        if (abort) begin
          nxt        = IDLE;
          take_abort = 1'b1;
        end else if (mem.mem_ready) begin
          nxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (abort) begin
          nxt        = IDLE;
          take_abort = 1'b1;
        end else begin
          nxt = WR_REQ;
        end
      end
      WR_REQ: begin
        if (abort) begin
          nxt        = IDLE;
          take_abort = 1'b1;
        end else if (mem.mem_ready) begin
          nxt = last ? FINISH : RD_REQ;
        end
      end
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Output flags are registered from the next state so they are Moore.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      ren     <= 1'b0;
      wen     <= 1'b0;
      reg_wen <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      state   <= nxt;
      ren     <= (nxt == RD_REQ);
      wen     <= (nxt == WR_REQ);
      reg_wen <= (nxt == RD_WAIT);
      busy    <= (nxt != IDLE);
      done    <= (nxt == FINISH);
      aborted <= take_abort;
    end
  end

  always_comb begin
    mem.mem_addr = '0;
    unique case (1'b1)
      ren:     mem.mem_addr = src_a;
      wen:     mem.mem_addr = dst_a;
      default: mem.mem_addr = '0;
    endcase
  end

  assign mem.mem_ren   = ren;
  assign mem.mem_wen   = wen;
  assign mem.mem_wdata = wen ? reg_data : '0;
  assign reg_wdata     = reg_wen ? mem.mem_rdata : '0;
endmodule

// File: tb/tb_dma_copy_ctrl.sv
// Scoreboard bench for dma_copy_ctrl with a stallable byte-memory model.
module tb_dma_copy_ctrl;
  import dma_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       start;
  logic       abort;
  logic [7:0] src_addr;
  logic [7:0] dst_addr;
  logic [7:0] length;
  logic       reg_wen;
  logic [7:0] reg_wdata;
  logic [7:0] reg_data = 8'h00;
  logic       busy;
  logic       done;
  logic       aborted;

  int ncmp = 0;
  int nerr = 0;

  logic [7:0]  mem [256];
  int          scnt = 0;
  int          stall_n = 0;
  logic [15:0] exp_q[$];
  logic [15:0] act_q[$];
  logic [7:0]  rd_q[$];
  int          busy_cnt = 0;
  int          done_seen = 0;
  int          ab_seen = 0;

  logic        prev_stall = 1'b0;
  logic [17:0] prev_sig = '0;

  always #5 CLK = ~CLK;

  dma_copy_ctrl_if #(.ADDR_W(8)) m ();

  dma_copy_ctrl #(
    .ADDR_W(8),
    .LEN_W (8)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .start    (start),
    .abort    (abort),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .length   (length),
    .mem      (m),
    .reg_wen  (reg_wen),
    .reg_wdata(reg_wdata),
    .reg_data (reg_data),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted)
  );

  assign m.mem_ready =
    !((m.mem_ren || m.mem_wen) && scnt < stall_n);

  // Memory, staging register and stall generator.
  always @(posedge CLK) begin
    if (nRST) begin
      if (reg_wen) reg_data <= reg_wdata;
      if (m.mem_ren && m.mem_ready) begin
        m.mem_rdata <= mem[m.mem_addr];
        rd_q.push_back(m.mem_addr);
      end
      if (m.mem_wen && m.mem_ready) begin
        mem[m.mem_addr] <= m.mem_wdata;
        act_q.push_back({m.mem_addr, m.mem_wdata});
      end
      if (m.mem_ren || m.mem_wen)
        scnt <= m.mem_ready ? 0 : scnt + 1;
    end
  end

  always @(negedge CLK) begin
    if (nRST && busy) begin
      busy_cnt++;
      ncmp++;
      if (m.mem_ren && m.mem_wen) begin
        nerr++;
        $display("FAIL excl: ren=1 wen=1 at %0t, need one", $time);
      end
    end
    if (nRST && done) done_seen++;
    if (nRST && aborted) ab_seen++;
    if (nRST && prev_stall) begin
      ncmp++;
      if ({m.mem_ren, m.mem_wen, m.mem_addr, m.mem_wdata}
          !== prev_sig) begin
        nerr++;
        $display("FAIL stall_hold: got %h need %h",
                 {m.mem_ren, m.mem_wen, m.mem_addr, m.mem_wdata},
                 prev_sig);
      end
    end
    prev_stall = nRST && (m.mem_ren || m.mem_wen) && !m.mem_ready;
    prev_sig   = {m.mem_ren, m.mem_wen, m.mem_addr, m.mem_wdata};
  end

  task automatic clear_sb();
    exp_q.delete();
    act_q.delete();
    rd_q.delete();
    busy_cnt  = 0;
    done_seen = 0;
    ab_seen   = 0;
  endtask

  task automatic fill(input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) mem[8'(s + i)] = 8'($urandom);
  endtask

  // Drive one start pulse; expectations for the first nexp bytes.
  task automatic kick(input logic [7:0] s, input logic [7:0] d,
                      input logic [7:0] l, input int nexp);
    for (int i = 0; i < nexp; i++)
      exp_q.push_back({8'(d + i), mem[8'(s + i)]});
    src_addr = s;
    dst_addr = d;
    length   = l;
    start    = 1'b1;
    @(negedge CLK);
    start    = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge CLK);
      n++;
    end
    ncmp++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL %s_timeout: busy=%b after %0d, need 0",
               tag, busy, n);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; start = 1'b0; abort = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0;
    stall_n = 0;
    repeat (2) @(negedge CLK);
    ncmp++;
    if ({m.mem_ren, m.mem_wen, m.mem_addr, m.mem_wdata, reg_wen,
         reg_wdata, busy, done, aborted} !== '0) begin
      nerr++;
      $display("FAIL reset_outs: ren=%b wen=%b addr=%h busy=%b, need 0",
               m.mem_ren, m.mem_wen, m.mem_addr, busy);
    end
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_basic();
    logic [15:0] a, e;
    clear_sb();
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3;
    kick(8'h10, 8'h80, 8'd3, 3);
    wait_idle(100, "basic");
    ncmp++;
    if (act_q.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL basic_wcount: got %0d need %0d",
               act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); ncmp++;
      if (a !== e) begin
        nerr++;
        $display("FAIL basic_write: got %h need %h", a, e);
      end
    end
    ncmp++;
    if (busy_cnt != 10) begin
      nerr++;
      $display("FAIL basic_busy: got %0d need 10", busy_cnt);
    end
    ncmp++;
    if (done_seen != 1 || ab_seen != 0) begin
      nerr++;
      $display("FAIL basic_pulses: done=%0d ab=%0d need 1/0",
               done_seen, ab_seen);
    end
  endtask

  task automatic test_zero_len();
    clear_sb();
    kick(8'h40, 8'h90, 8'd0, 0);
    ncmp++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      nerr++;
      $display("FAIL zero_t1: done=%b busy=%b need 1/1", done, busy);
    end
    wait_idle(20, "zero");
    ncmp++;
    if (busy_cnt != 1 || rd_q.size() != 0 || act_q.size() != 0) begin
      nerr++;
      $display("FAIL zero_len: busy=%0d rd=%0d wr=%0d need 1/0/0",
               busy_cnt, rd_q.size(), act_q.size());
    end
  endtask

  task automatic test_stall_wrap();
    logic [15:0] a, e;
    logic [7:0]  ra;
    int          need;
    clear_sb();
    stall_n = 2;
    fill(8'hFE, 4);
    kick(8'hFE, 8'h60, 8'd4, 4);
    wait_idle(400, "stall");
    for (int i = 0; i < 4; i++) begin
      ncmp++;
      ra = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
      if (ra !== 8'(8'hFE + i)) begin
        nerr++;
        $display("FAIL wrap_raddr%0d: got %h need %h",
                 i, ra, 8'(8'hFE + i));
      end
    end
    ncmp++;
    if (act_q.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL stall_wcount: got %0d need %0d",
               act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); ncmp++;
      if (a !== e) begin
        nerr++;
        $display("FAIL stall_write: got %h need %h", a, e);
      end
    end
    // 3 cycles per byte, FINISH, and 2 stalls on each of 8 requests.
    need = 3 * 4 + 1 + 2 * 2 * 4;
    ncmp++;
    if (busy_cnt != need) begin
      nerr++;
      $display("FAIL stall_busy: got %0d need %0d", busy_cnt, need);
    end
    stall_n = 0;
  endtask

  task automatic test_abort();
    logic [15:0] a, e;
    int k = 0;
    int n = 0;
    clear_sb();
    fill(8'h20, 5);
    kick(8'h20, 8'hA0, 8'd5, 1);
    while (k < 2 && n < 50) begin
      if (reg_wen) k++;
      if (k < 2) begin
        @(negedge CLK);
        n++;
      end
    end
    ncmp++;
    if (k != 2) begin
      nerr++;
      $display("FAIL abort_reach: rd_wait seen %0d need 2", k);
    end
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    ncmp++;
    if (busy !== 1'b0 || aborted !== 1'b1) begin
      nerr++;
      $display("FAIL abort_next: busy=%b aborted=%b need 0/1",
               busy, aborted);
    end
    repeat (5) @(negedge CLK);
    ncmp++;
    if (ab_seen != 1 || done_seen != 0 || rd_q.size() != 2) begin
      nerr++;
      $display("FAIL abort_pulses: ab=%0d done=%0d rd=%0d need 1/0/2",
               ab_seen, done_seen, rd_q.size());
    end
    ncmp++;
    if (act_q.size() != 1) begin
      nerr++;
      $display("FAIL abort_wcount: got %0d need 1", act_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); ncmp++;
      if (a !== e) begin
        nerr++;
        $display("FAIL abort_write: got %h need %h", a, e);
      end
    end
  endtask

  task automatic test_start_busy();
    logic [15:0] a, e;
    clear_sb();
    fill(8'h30, 4);
    fill(8'h70, 2);
    kick(8'h30, 8'hC0, 8'd4, 4);
    repeat (4) @(negedge CLK);
    src_addr = 8'h70; dst_addr = 8'hE0; length = 8'd2;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_idle(100, "sbusy");
    ncmp++;
    if (act_q.size() != exp_q.size()) begin
      nerr++;
      $display("FAIL sbusy_wcount: got %0d need %0d",
               act_q.size(), exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); ncmp++;
      if (a !== e) begin
        nerr++;
        $display("FAIL sbusy_write: got %h need %h", a, e);
      end
    end
    ncmp++;
    if (busy_cnt != 13 || done_seen != 1) begin
      nerr++;
      $display("FAIL sbusy_busy: busy=%0d done=%0d need 13/1",
               busy_cnt, done_seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] a, e;
    int n = 0;
    clear_sb();
    fill(8'h50, 3);
    kick(8'h50, 8'hD0, 8'd3, 0);
    while (!m.mem_wen && n < 50) begin
      @(negedge CLK);
      n++;
    end
    nRST = 1'b0;
    @(negedge CLK);
    ncmp++;
    if ({m.mem_ren, m.mem_wen, m.mem_addr, m.mem_wdata, reg_wen,
         reg_wdata, busy, done, aborted} !== '0) begin
      nerr++;
      $display("FAIL rstmid_outs: wen=%b addr=%h busy=%b, need 0",
               m.mem_wen, m.mem_addr, busy);
    end
    nRST = 1'b1;
    @(negedge CLK);
    ncmp++;
    if (done_seen != 0 || ab_seen != 0 || act_q.size() != 0) begin
      nerr++;
      $display("FAIL rstmid_pulses: done=%0d ab=%0d wr=%0d need 0",
               done_seen, ab_seen, act_q.size());
    end
    clear_sb();
    kick(8'h50, 8'hD0, 8'd3, 3);
    wait_idle(100, "rstmid");
    ncmp++;
    if (act_q.size() != exp_q.size() || busy_cnt != 10) begin
      nerr++;
      $display("FAIL rstmid_redo: wr=%0d busy=%0d need %0d/10",
               act_q.size(), busy_cnt, exp_q.size());
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); ncmp++;
      if (a !== e) begin
        nerr++;
        $display("FAIL rstmid_write: got %h need %h", a, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] a, e;
    int n = 0;
    clear_sb();
    fill(8'h00, 2);
    fill(8'hB0, 2);
    kick(8'h00, 8'h40, 8'd2, 2);
    while (!done && n < 50) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    ncmp++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL b2b_idle: busy=%b need 0", busy);
    end
    kick(8'hB0, 8'h50, 8'd2, 2);
    ncmp++;
    if (busy !== 1'b1 || m.mem_ren !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_start: busy=%b ren=%b need 1/1",
               busy, m.mem_ren);
    end
    wait_idle(100, "b2b");
    ncmp++;
    if (act_q.size() != 4 || done_seen != 2 || busy_cnt != 14) begin
      nerr++;
      $display("FAIL b2b_count: wr=%0d done=%0d busy=%0d need 4/2/14",
               act_q.size(), done_seen, busy_cnt);
    end
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front(); e = exp_q.pop_front(); ncmp++;
      if (a !== e) begin
        nerr++;
        $display("FAIL b2b_write: got %h need %h", a, e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_zero_len();
    test_stall_wrap();
    test_abort();
    test_start_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
